// File: rtl/lsu_mem_initiator.sv
// M-stage load/store initiator over a req/ack data-memory handshake.
// Define LSU_TRACE_EN to print a trace line for every acked store.
module lsu_mem_initiator #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       alo_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             adel_q, ades_q;

  logic is_st, is_word, is_half, misal;
  logic start, ack_hit, tout;

  function automatic logic [3:0] lane_be(
    input logic [2:0] op,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (op)
      OP_SW:   be = 4'b1111;
      OP_SH:   be = a[1] ? 4'b1100 : 4'b0011;
      OP_SB:   be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wd(
    input logic [2:0]  op,
    input logic [31:0] d
  );
    logic [31:0] w;
    w = d;
    unique case (op)
      OP_SH:   w = {2{d[15:0]}};
      OP_SB:   w = {4{d[7:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [2:0]  op,
    input logic [1:0]  a,
    input logic [31:0] rd
  );
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = a[1] ? rd[31:16] : rd[15:0];
    b = rd[{a, 3'b000} +: 8];
    unique case (op)
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      OP_LW:   r = rd;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign is_st   = mem_op[2] & |mem_op[1:0];
  assign is_word = (mem_op == OP_LW) | (mem_op == OP_SW);
  assign is_half = (mem_op == OP_LH) | (mem_op == OP_LHU)
                 | (mem_op == OP_SH);
  assign misal   = (is_word & |addr[1:0]) | (is_half & addr[0]);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ack_hit = 1'b0;
    tout    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && !misal) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack beats a timeout landing in the same cycle
        if (m_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tout    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall = (state_q == IDLE && mem_valid && !misal)
               | (state_q == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= 3'b000;
      alo_q   <= 2'b00;
      pc_q    <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 32'h0;
      m_be    <= 4'b0000;
      m_wdata <= 32'h0;
    end else begin
      adel_q <= (state_q == IDLE) & mem_valid & misal & ~is_st;
      ades_q <= (state_q == IDLE) & mem_valid & misal & is_st;
      if (start) begin
        op_q    <= mem_op;
        alo_q   <= addr[1:0];
        pc_q    <= pc;
        cnt_q   <= '0;
        err_q   <= 1'b0;
        rdata_q <= 32'h0;
        m_req   <= 1'b1;
        m_we    <= is_st;
        m_addr  <= {addr[31:2], 2'b00};
        m_be    <= lane_be(mem_op, addr[1:0]);
        m_wdata <= is_st ? lane_wd(mem_op, wdata) : 32'h0;
      end
      if (ack_hit) begin
        m_req   <= 1'b0;
        rdata_q <= load_ext(op_q, alo_q, m_rdata);
      end else if (tout) begin
        m_req   <= 1'b0;
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign done     = (state_q == DONE);
  assign bus_err  = done & err_q;
  assign rdata    = rdata_q;
  assign exc_adel = adel_q;
  assign exc_ades = ades_q;

`ifdef LSU_TRACE_EN
  logic [31:0] merged;
  assign merged = m_wdata & {{8{m_be[3]}}, {8{m_be[2]}},
                             {8{m_be[1]}}, {8{m_be[0]}}};

  always_ff @(posedge clk) begin
    if (ack_hit && m_we)
      $display("%d@%h: *%h <= %h", $time, pc_q, m_addr, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized bench for lsu_mem_initiator.
// Reference model computes lanes/extension arithmetically per access.
module tb_lsu_mem_initiator;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        exc_adel;
  logic        exc_ades;
  logic        bus_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  int n_chk = 0;
  int n_err = 0;

  lsu_mem_initiator #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .pc(pc),
    .stall(stall), .rdata(rdata), .done(done),
    .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input int op);
    if (op == 0 || op == 5) return 4;
    if (op == 1 || op == 2 || op == 6) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input int op,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz;
    logic [31:0] mask, v;
    sz = op_size(op);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    v = (rd >> (8 * (a % 4))) & mask;
    if ((op == 1 || op == 3) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_wd(input int op,
                                         input logic [31:0] d);
    int sz;
    logic [31:0] w;
    sz = op_size(op);
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      w[8 * i +: 8] = d[8 * (i % sz) +: 8];
    return w;
  endfunction

  // delay: REQ cycles before ack; negative or >= TMO means no ack in time
  task automatic txn(input int op, input logic [31:0] a,
                     input logic [31:0] d, input int delay,
                     input logic [31:0] rd);
    int sz, cyc, exp_req;
    bit st, al, abort, fin;
    logic [3:0] ebe;
    sz = op_size(op);
    st = (op >= 5);
    al = (a % sz) == 0;
    abort = (delay < 0) || (delay >= TMO);
    exp_req = abort ? TMO : delay + 1;
    ebe = st ? 4'((((1 << sz) - 1) << (a % 4)) & 15) : 4'h0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_op = 3'(op);
    addr = a;
    wdata = d;
    pc = $urandom;
    m_rdata = rd;
    #1;
    chk("stall_accept", 32'(stall), 32'(al));
    if (!al) begin
      @(negedge clk);
      mem_valid = 1'b0;
      chk("exc_adel", 32'(exc_adel), 32'(!st));
      chk("exc_ades", 32'(exc_ades), 32'(st));
      chk("noreq_misal", 32'(m_req), 0);
      @(negedge clk);
      chk("exc_clear", 32'({exc_adel, exc_ades}), 0);
      return;
    end
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      if (m_req) begin
        chk("stall_req", 32'(stall), 1);
        chk("done_req", 32'(done), 0);
        chk("m_addr", m_addr, a & 32'hFFFF_FFFC);
        chk("m_we", 32'(m_we), 32'(st));
        chk("m_be", 32'(m_be), 32'(ebe));
        if (st) chk("m_wdata", m_wdata, ref_wd(op, d));
        m_ack = (cyc == delay);
        cyc++;
      end else begin
        fin = 1;
        m_ack = 1'b0;
        chk("done", 32'(done), 1);
        chk("stall_done", 32'(stall), 0);
        chk("bus_err", 32'(bus_err), 32'(abort));
        if (!st)
          chk("rdata", rdata, abort ? 32'h0 : ref_load(op, a, rd));
        mem_valid = 1'b0;
      end
    end
    chk("req_cycles", cyc, exp_req);
    @(negedge clk);
    chk("done_pulse", 32'({done, bus_err}), 0);
  endtask

  initial begin
    #1;
    chk("rst_req", 32'(m_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", 32'(stall), 0);
    @(negedge clk);
    reset = 1'b1;

    txn(5, 32'h10, 32'hDEADBEEF, 2, 32'h0);
    txn(3, 32'h13, 32'h0, 0, 32'h80112233);
    txn(4, 32'h13, 32'h0, 1, 32'h80112233);
    txn(1, 32'h12, 32'h0, 0, 32'h80017FFF);
    txn(6, 32'h12, 32'h0000ABCD, 0, 32'h0);
    txn(0, 32'h02, 32'h0, 0, 32'h0);
    txn(6, 32'h01, 32'h1234, 0, 32'h0);
    txn(0, 32'h40, 32'h0, -1, 32'h5555AAAA);
    txn(2, 32'h22, 32'h0, TMO - 1, 32'hFEDC8765);

    // stray ack while idle
    @(negedge clk);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("idle_ack_req", 32'(m_req), 0);
    chk("idle_ack_done", 32'(done), 0);

    // reset while a request is outstanding
    @(negedge clk);
    mem_valid = 1'b1;
    mem_op = 3'b000;
    addr = 32'h20;
    @(negedge clk);
    chk("pre_rst_req", 32'(m_req), 1);
    mem_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk("async_rst_req", 32'(m_req), 0);
    @(negedge clk);
    reset = 1'b1;
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("late_ack_done", 32'(done), 0);
    chk("late_ack_req", 32'(m_req), 0);

    for (int i = 0; i < 60; i++) begin
      int op, dl;
      logic [31:0] a;
      op = int'($urandom_range(0, 7));
      a = $urandom;
      dl = int'($urandom_range(0, TMO + 1));
      if (dl == TMO + 1) dl = -1;
      txn(op, a, $urandom, dl, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
